block_serializer_64x12bit: RTL

- Parallel-in, serial-out reader for 8x8 blocks of 12-bit samples/coefficients.
- Accepts a whole block as one packed 768-bit word, then streams it out one 12-bit element per accepted cycle, either in raster order or JPEG zigzag order.
- Two-block ping-pong storage: the next block loads while the current one drains.
- Sits between the block-parallel DCT/quantizer stage and the serial entropy-coding path. It is the read-side counterpart of the 64x12 collecting buffer.

---
 rtl/block_serializer_64x12bit_if.sv | 30 +++
 rtl/block_serializer_64x12bit.sv | 92 +++++++++
 2 files changed

// File: rtl/block_serializer_64x12bit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | block_serializer_64x12bit_if                                           |
// | Block-in / element-out stream bundle for the 64x12 block serializer.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface block_serializer_64x12bit_if #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 64
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DEPTH*DATA_WIDTH-1:0]   block_768bits;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [5:0]                    out_index;
  logic                          out_last;

  modport master (
    output in_valid, block_768bits, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, block_768bits, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/block_serializer_64x12bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | block_serializer_64x12bit                                              |
// | Ping-pong 8x8 block reader: 768-bit parallel in, 12-bit serial out in  |
// | raster order, or JPEG zigzag order when ZIGZAG_ORDER_EN is defined.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module block_serializer_64x12bit #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  block_serializer_64x12bit_if.slave   bus
);

  localparam logic [5:0] c_LAST = 6'd63;

  logic [DATA_WIDTH-1:0] r_bank [0:1][0:DEPTH-1];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic [5:0]            r_n;
  logic                  r_in_ready;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_final_pop;
  logic [1:0]            w_cnt_next;
  logic [5:0]            w_addr;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_pop       = (r_cnt != 2'd0) && bus.out_ready;
  assign w_final_pop = w_pop && (r_n == c_LAST);

  always_comb begin
    w_cnt_next = r_cnt + {1'b0, w_accept} - {1'b0, w_final_pop};
  end

  // Bank under wp is always free when in_ready is high, including the
  // accept-with-final-pop case, so no extra steering is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
      r_n        <= 6'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_accept)    r_wp <= ~r_wp;
      if (w_final_pop) r_rp <= ~r_rp;
      if (w_pop)       r_n  <= r_n + 6'd1;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_cnt_next < 2'd2);
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_bank[r_wp][k] <= bus.block_768bits[(DEPTH-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef ZIGZAG_ORDER_EN
  // Entry n sits at bits [(63-n)*6 +: 6]; entry 0 is the MSB field.
  localparam logic [383:0] c_ZZ_ROM = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  logic [8:0] w_rom_lsb;
  assign w_rom_lsb = {3'b000, c_LAST - r_n} * 9'd6;
  assign w_addr    = c_ZZ_ROM[w_rom_lsb +: 6];
`else
  assign w_addr = r_n;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_data  = r_bank[r_rp][w_addr];
  assign bus.out_index = r_n;
  assign bus.out_last  = (r_cnt != 2'd0) && (r_n == c_LAST);

endmodule
`default_nettype wire
